div_16x8_seq: RTL and testbench

DIV_16X8_SEQ -- requirements
Module: div_16x8_seq

---
 rtl/div_16x8_seq.sv | 141 ++++++++++++++
 tb/tb_div_16x8_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/div_16x8_seq.sv
// Sequential 16/8 unsigned restoring divider with valid/ready handshakes on both sides.
// APX skips the last APX quotient iterations; the dropped quotient LSBs read as zero.
module div_16x8_seq #(
    parameter int APX = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        dz
);

    // Handshake: an operand pair transfers on an edge where in_valid && in_ready;
    // a result transfers on an edge where out_valid && out_ready. Neither side
    // may take back what it has offered until that transfer edge.

    localparam int N = 16 - APX;
    localparam logic [4:0] LAST_CNT = 5'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] dvd_q, dvd_d;
    logic [7:0]  dvs_q, dvs_d;
    logic [7:0]  prem_q, prem_d;
    logic [15:0] qacc_q, qacc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] quotient_q, quotient_d;
    logic [7:0]  remainder_q, remainder_d;
    logic        dz_q, dz_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;

    logic [8:0]  trial;
    logic [8:0]  diff;
    logic        qbit;
    logic [7:0]  prem_next;
    logic [15:0] qacc_next;

    // The dividend register shifts left each iteration, so bit 15 is always the next bit.
    always_comb begin
        trial     = {prem_q, dvd_q[15]};
        diff      = trial - {1'b0, dvs_q};
        qbit      = (trial >= {1'b0, dvs_q});
        // On restore trial < divisor <= 255, so its top bit is zero.
        prem_next = qbit ? diff[7:0] : trial[7:0];
        qacc_next = {qacc_q[14:0], qbit};

        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        qacc_d      = qacc_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    prem_d  = 8'd0;
                    qacc_d  = 16'd0;
                    cnt_d   = 5'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (dvs_q == 8'd0) begin
                    state_d     = DONE;
                    quotient_d  = 16'hFFFF;
                    remainder_d = dvd_q[7:0];
                    dz_d        = 1'b1;
                end else begin
                    dvd_d  = {dvd_q[14:0], 1'b0};
                    prem_d = prem_next;
                    qacc_d = qacc_next;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d     = DONE;
                        quotient_d  = qacc_next << APX;
                        remainder_d = prem_next;
                        dz_d        = 1'b0;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= 16'd0;
            dvs_q       <= 8'd0;
            prem_q      <= 8'd0;
            qacc_q      <= 16'd0;
            cnt_q       <= 5'd0;
            quotient_q  <= 16'd0;
            remainder_q <= 8'd0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            qacc_q      <= qacc_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_div_16x8_seq.sv
// Directed bench for div_16x8_seq: one instance at APX=0 and one at APX=4,
// each with its own handshake/operand signals and a shared clock and reset.
module tb_div_16x8_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [1:0]  dz;
    logic [15:0] dividend [2];
    logic [15:0] quotient [2];
    logic [7:0]  divisor [2];
    logic [7:0]  remainder [2];

    int checks   = 0;
    int failures = 0;
    logic [24:0] exp_q[$];

    always #5 clk = ~clk;

    div_16x8_seq #(.APX(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .dividend  (dividend[0]),
        .divisor   (divisor[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .quotient  (quotient[0]),
        .remainder (remainder[0]),
        .dz        (dz[0])
    );

    div_16x8_seq #(.APX(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .dividend  (dividend[1]),
        .divisor   (divisor[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .quotient  (quotient[1]),
        .remainder (remainder[1]),
        .dz        (dz[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input int sel, input string tag);
        check({tag, "_in_ready"},  32'(in_ready[sel]),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid[sel]), 32'd0);
        check({tag, "_quotient"},  32'(quotient[sel]),  32'd0);
        check({tag, "_remainder"}, 32'(remainder[sel]), 32'd0);
        check({tag, "_dz"},        32'(dz[sel]),        32'd0);
    endtask

    // Offers one operand pair, waits for the result, optionally holds it for
    // `hold` cycles with in_valid pulses, then consumes it.
    task automatic run_div(input int sel, input logic [15:0] a, input logic [7:0] b,
                           input logic [15:0] eq, input logic [7:0] er, input logic edz,
                           input int elat, input int hold);
        int lat;
        logic [24:0] e;
        string t;
        t = $sformatf("u%0d_%0h_%0h", sel, a, b);
        lat = 0;
        @(negedge clk);
        while (!in_ready[sel] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({t, "_ready_before"}, 32'(in_ready[sel]), 32'd1);
        in_valid[sel] = 1'b1;
        dividend[sel] = a;
        divisor[sel]  = b;
        exp_q.push_back({eq, er, edz});
        @(posedge clk);
        @(negedge clk);
        in_valid[sel] = 1'b0;
        dividend[sel] = ~a;
        divisor[sel]  = ~b;
        lat = 0;
        while (!out_valid[sel] && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({t, "_latency"}, 32'(lat), 32'(elat));
        e = exp_q.pop_front();
        check({t, "_quotient"},  32'(quotient[sel]),  32'(e[24:9]));
        check({t, "_remainder"}, 32'(remainder[sel]), 32'(e[8:1]));
        check({t, "_dz"},        32'(dz[sel]),        32'(e[0]));
        for (int i = 0; i < hold; i++) begin
            in_valid[sel] = 1'b1;
            dividend[sel] = 16'h5555;
            divisor[sel]  = 8'd3;
            @(posedge clk);
            @(negedge clk);
            in_valid[sel] = 1'b0;
            check({t, "_hold_valid"},     32'(out_valid[sel]), 32'd1);
            check({t, "_hold_in_ready"},  32'(in_ready[sel]),  32'd0);
            check({t, "_hold_quotient"},  32'(quotient[sel]),  32'(e[24:9]));
            check({t, "_hold_remainder"}, 32'(remainder[sel]), 32'(e[8:1]));
            check({t, "_hold_dz"},        32'(dz[sel]),        32'(e[0]));
        end
        out_ready[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[sel] = 1'b0;
        check({t, "_drained_valid"}, 32'(out_valid[sel]), 32'd0);
        check({t, "_drained_ready"}, 32'(in_ready[sel]),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_valid  = 2'b00;
        out_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            dividend[i] = 16'd0;
            divisor[i]  = 8'd0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs(0, "reset_u0");
        check_reset_outputs(1, "reset_u1");
        rst = 1'b0;

        run_div(0, 16'd1000,  8'd7,   16'h008E, 8'd6,    1'b0, 16, 0);
        run_div(0, 16'hFFFF,  8'd1,   16'hFFFF, 8'd0,    1'b0, 16, 0);
        run_div(0, 16'd5,     8'd200, 16'h0000, 8'd5,    1'b0, 16, 0);
        run_div(0, 16'h1234,  8'd0,   16'hFFFF, 8'h34,   1'b1, 1,  0);
        run_div(0, 16'd50000, 8'd123, 16'h0196, 8'd62,   1'b0, 16, 5);
        run_div(0, 16'hFFFF,  8'd255, 16'h0101, 8'd0,    1'b0, 16, 0);
        run_div(1, 16'd1000,  8'd7,   16'h0080, 8'd6,    1'b0, 12, 0);
        run_div(1, 16'h1234,  8'd0,   16'hFFFF, 8'h34,   1'b1, 1,  0);
        run_div(1, 16'd255,   8'd16,  16'h0000, 8'd15,   1'b0, 12, 0);

        // Reset in the middle of a division: nothing may come out afterwards.
        @(negedge clk);
        in_valid[0] = 1'b1;
        dividend[0] = 16'hABCD;
        divisor[0]  = 8'd9;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("midbusy_out_valid", 32'(out_valid[0]), 32'd0);
        check("midbusy_in_ready",  32'(in_ready[0]),  32'd0);
        #2 rst = 1'b1;
        #1 check_reset_outputs(0, "async_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_reset_no_result", 32'(out_valid[0]), 32'd0);
        end
        run_div(0, 16'd300, 8'd17, 16'd17, 8'd11, 1'b0, 16, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
